// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, default opcodes,
// IDCODE field layout and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    StExit2Dr   = 4'h0,
    StExit1Dr   = 4'h1,
    StShiftDr   = 4'h2,
    StPauseDr   = 4'h3,
    StSelectIr  = 4'h4,
    StUpdateDr  = 4'h5,
    StCaptureDr = 4'h6,
    StSelectDr  = 4'h7,
    StExit2Ir   = 4'h8,
    StExit1Ir   = 4'h9,
    StShiftIr   = 4'hA,
    StPauseIr   = 4'hB,
    StIdle      = 4'hC,
    StUpdateIr  = 4'hD,
    StCaptureIr = 4'hE,
    StReset     = 4'hF
  } tap_state_e;

  localparam logic [3:0] OpExtestDef = 4'h0;
  localparam logic [3:0] OpSampleDef = 4'h1;
  localparam logic [3:0] OpInscanDef = 4'h2;
  localparam logic [3:0] OpIdcodeDef = 4'h3;

  localparam int unsigned IdVersionW = 4;
  localparam int unsigned IdPartW    = 16;
  localparam int unsigned IdManufW   = 11;
  localparam int unsigned IdFixedW   = 1;
  localparam int unsigned IdW        = IdVersionW + IdPartW + IdManufW + IdFixedW;

  function automatic tap_state_e tap_next(input tap_state_e st, input logic tms);
    tap_state_e nxt;
    unique case (st)
      StReset:     nxt = tms ? StReset    : StIdle;
      StIdle:      nxt = tms ? StSelectDr : StIdle;
      StSelectDr:  nxt = tms ? StSelectIr : StCaptureDr;
      StCaptureDr: nxt = tms ? StExit1Dr  : StShiftDr;
      StShiftDr:   nxt = tms ? StExit1Dr  : StShiftDr;
      StExit1Dr:   nxt = tms ? StUpdateDr : StPauseDr;
      StPauseDr:   nxt = tms ? StExit2Dr  : StPauseDr;
      StExit2Dr:   nxt = tms ? StUpdateDr : StShiftDr;
      StUpdateDr:  nxt = tms ? StSelectDr : StIdle;
      StSelectIr:  nxt = tms ? StReset    : StCaptureIr;
      StCaptureIr: nxt = tms ? StExit1Ir  : StShiftIr;
      StShiftIr:   nxt = tms ? StExit1Ir  : StShiftIr;
      StExit1Ir:   nxt = tms ? StUpdateIr : StPauseIr;
      StPauseIr:   nxt = tms ? StExit2Ir  : StPauseIr;
      StExit2Ir:   nxt = tms ? StUpdateIr : StShiftIr;
      StUpdateIr:  nxt = tms ? StSelectDr : StIdle;
      default:     nxt = StReset;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with registered state and per-state decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       next_reset_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = tap_next(state_q, tms_i);
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    capture_dr_o = 1'b0;
    shift_dr_o   = 1'b0;
    update_dr_o  = 1'b0;
    capture_ir_o = 1'b0;
    shift_ir_o   = 1'b0;
    update_ir_o  = 1'b0;
    unique case (state_q)
      StCaptureDr: capture_dr_o = 1'b1;
      StShiftDr:   shift_dr_o   = 1'b1;
      StUpdateDr:  update_dr_o  = 1'b1;
      StCaptureIr: capture_ir_o = 1'b1;
      StShiftIr:   shift_ir_o   = 1'b1;
      StUpdateIr:  update_ir_o  = 1'b1;
      default: ;
    endcase
  end

  // Lets the top reload the instruction on the same edge that enters reset.
  assign next_reset_o = (state_d == StReset);
  assign state_o      = state_q;

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised TAP top: IR, IDCODE, bypass, DR mux, falling-edge TDO and
// the capture/shift/update strobes for external scan chains.
module jtag_tap_param
  import jtag_pkg::*;
#(
  parameter int unsigned     IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0] OP_EXTEST  = IR_W'(OpExtestDef),
  parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(OpSampleDef),
  parameter logic [IR_W-1:0] OP_INSCAN  = IR_W'(OpInscanDef),
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(OpIdcodeDef),
  parameter logic [IR_W-1:0] OP_BYPASS  = '1
) (
  input  logic            TCK,
  input  logic            TRST_b,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            tdo_en,
  input  logic            bsr_tdo,
  input  logic            in_scan_tdo,
  output logic            clockdr,
  output logic            capturedr,
  output logic            shiftdr,
  output logic            updatedr,
  output logic            bsr_sel,
  output logic            bsr_extest,
  output logic            in_scan_sel,
  output logic [IR_W-1:0] inst,
  output logic [3:0]      tap_state
);

  localparam logic [IR_W-1:0] IrCapture = IR_W'(2'b01);

  tap_state_e state;
  logic next_reset, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .tck_i        (TCK),
    .trst_ni      (TRST_b),
    .tms_i        (TMS),
    .state_o      (state),
    .next_reset_o (next_reset),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (sh_dr),
    .update_dr_o  (upd_dr),
    .capture_ir_o (cap_ir),
    .shift_ir_o   (sh_ir),
    .update_ir_o  (upd_ir)
  );

  logic [IR_W-1:0] ir_q, ir_d, inst_q, inst_d;
  logic [IdW-1:0]  id_q, id_d;
  logic            bypass_q, bypass_d;
  logic            tdo_q, tdo_d, tdo_en_q, tdo_en_d;

  logic sel_extest, sel_sample, sel_inscan, sel_idcode, sel_bypass, dr_bit;

  always_comb begin
    sel_extest = (inst_q == OP_EXTEST);
    sel_sample = (inst_q == OP_SAMPLE);
    sel_inscan = (inst_q == OP_INSCAN);
    sel_idcode = (inst_q == OP_IDCODE);
    // Undefined opcodes fall through to the bypass flop.
    sel_bypass = (inst_q == OP_BYPASS) ||
                 !(sel_extest || sel_sample || sel_inscan || sel_idcode);
  end

  always_comb begin
    dr_bit = bypass_q;
    if (sel_extest || sel_sample) begin
      dr_bit = bsr_tdo;
    end else if (sel_inscan) begin
      dr_bit = in_scan_tdo;
    end else if (sel_idcode) begin
      dr_bit = id_q[0];
    end
  end

  always_comb begin
    ir_d     = ir_q;
    inst_d   = inst_q;
    id_d     = id_q;
    bypass_d = bypass_q;
    if (cap_ir) begin
      ir_d = IrCapture;
    end else if (sh_ir) begin
      ir_d = {TDI, ir_q[IR_W-1:1]};
    end
    if (next_reset) begin
      inst_d = OP_IDCODE;
    end else if (upd_ir) begin
      inst_d = ir_q;
    end
    if (sel_idcode && cap_dr) begin
      id_d = IDCODE_VAL;
    end else if (sel_idcode && sh_dr) begin
      id_d = {TDI, id_q[IdW-1:1]};
    end
    if (sel_bypass && cap_dr) begin
      bypass_d = 1'b0;
    end else if (sel_bypass && sh_dr) begin
      bypass_d = TDI;
    end
  end

  always_ff @(posedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      ir_q     <= '0;
      inst_q   <= OP_IDCODE;
      id_q     <= IDCODE_VAL;
      bypass_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      inst_q   <= inst_d;
      id_q     <= id_d;
      bypass_q <= bypass_d;
    end
  end

  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = sh_ir || sh_dr;
    if (sh_ir) begin
      tdo_d = ir_q[0];
    end else if (sh_dr) begin
      tdo_d = dr_bit;
    end
  end

  // Falling-edge launch gives the receiver half a TCK period of setup.
  always_ff @(negedge TCK or negedge TRST_b) begin
    if (!TRST_b) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  // State only moves on the rising edge, so gating with ~TCK cannot glitch.
  assign clockdr     = ~TCK & (cap_dr | sh_dr) & (sel_extest | sel_sample | sel_inscan);
  assign updatedr    = ~TCK & upd_dr;
  assign capturedr   = cap_dr;
  assign shiftdr     = sh_dr;
  assign bsr_sel     = sel_extest | sel_sample;
  assign bsr_extest  = sel_extest;
  assign in_scan_sel = sel_inscan;
  assign inst        = inst_q;
  assign tap_state   = state;
  assign TDO         = tdo_q;
  assign tdo_en      = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed self-checking bench for jtag_tap_param with hand-computed vectors.
module tb_jtag_tap_param;

  logic       TCK, TRST_b, TMS, TDI, bsr_tdo, in_scan_tdo;
  logic       TDO, tdo_en, clockdr, capturedr, shiftdr, updatedr;
  logic       bsr_sel, bsr_extest, in_scan_sel;
  logic [3:0] inst, tap_state;

  jtag_tap_param dut (
    .TCK         (TCK),
    .TRST_b      (TRST_b),
    .TMS         (TMS),
    .TDI         (TDI),
    .TDO         (TDO),
    .tdo_en      (tdo_en),
    .bsr_tdo     (bsr_tdo),
    .in_scan_tdo (in_scan_tdo),
    .clockdr     (clockdr),
    .capturedr   (capturedr),
    .shiftdr     (shiftdr),
    .updatedr    (updatedr),
    .bsr_sel     (bsr_sel),
    .bsr_extest  (bsr_extest),
    .in_scan_sel (in_scan_sel),
    .inst        (inst),
    .tap_state   (tap_state)
  );

  initial begin
    TCK = 1'b0;
    forever #10 TCK = ~TCK;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt, clk_lo_cnt, upd_cnt, hi_viol;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Drive TMS/TDI, pass a rising edge, then sample just after the falling edge.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
    if (clockdr || updatedr) hi_viol++;
    @(negedge TCK);
    #1;
    if (tdo_en) en_cnt++;
    if (clockdr) clk_lo_cnt++;
    if (updatedr) upd_cnt++;
  endtask

  task automatic shift_ir(input logic [3:0] val, output logic [3:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cap[0] = TDO;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i]);
      if (i < 3) cap[i+1] = TDO;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] obs);
    obs = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    obs[0] = TDO;
    for (int i = 0; i < n; i++) begin
      step(1'b0, din[i]);
      obs[i+1] = TDO;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  int unsigned plen [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  logic [7:0]  pbits[16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                             8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  logic [3:0]  pst  [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                             4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] obs;
    logic [3:0]  cap;
    logic [7:0]  pb;
    en_cnt = 0; clk_lo_cnt = 0; upd_cnt = 0; hi_viol = 0;
    TRST_b = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0; in_scan_tdo = 1'b0;
    #25;
    check_eq("rst_state", 32'(tap_state), 32'hF);
    check_eq("rst_inst", 32'(inst), 32'h3);
    check_eq("rst_tdo", 32'({TDO, tdo_en}), 32'h0);
    check_eq("rst_drctl", 32'({clockdr, capturedr, shiftdr, updatedr}), 32'h0);
    check_eq("rst_sel", 32'({bsr_sel, bsr_extest, in_scan_sel}), 32'h0);
    TRST_b = 1'b1;
    @(negedge TCK);
    #1;

    // IDCODE scan straight out of reset
    step(1'b0, 1'b0);
    en_cnt = 0; clk_lo_cnt = 0;
    dr_scan(31, 32'h0, obs);
    check_eq("idcode_tdo", obs, 32'h1000_0001);
    check_eq("idcode_en_cnt", 32'(en_cnt), 32'd32);
    check_eq("idcode_no_clockdr", 32'(clk_lo_cnt), 32'd0);

    // BYPASS: one-bit delay with a captured leading 0
    shift_ir(4'hF, cap);
    check_eq("bypass_ir_cap", 32'(cap), 32'h1);
    check_eq("bypass_inst", 32'(inst), 32'hF);
    dr_scan(8, 32'hB3, obs);
    check_eq("bypass_tdo", 32'(obs[8:0]), 32'h166);
    check_eq("tdo_hold", 32'({TDO, tdo_en}), 32'h2);

    // INSCAN: TDO follows in_scan_tdo, not bsr_tdo
    shift_ir(4'h2, cap);
    check_eq("inscan_ir_cap", 32'(cap), 32'h1);
    check_eq("inscan_inst", 32'(inst), 32'h2);
    check_eq("inscan_sel", 32'({bsr_sel, in_scan_sel}), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    obs = '0;
    for (int i = 0; i < 3; i++) begin
      in_scan_tdo = (i != 1);
      bsr_tdo     = (i == 1);
      step(1'b0, 1'b0);
      obs[i] = TDO;
    end
    check_eq("inscan_tdo", obs, 32'h5);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // EXTEST: 4 clockdr low phases, one updatedr pulse, none while TCK high
    shift_ir(4'h0, cap);
    check_eq("extest_sel", 32'({bsr_sel, bsr_extest, in_scan_sel}), 32'h6);
    clk_lo_cnt = 0; upd_cnt = 0; hi_viol = 0;
    bsr_tdo = 1'b1; in_scan_tdo = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("extest_capturedr", 32'(capturedr), 32'h1);
    step(1'b0, 1'b0);
    check_eq("extest_tdo", 32'({TDO, shiftdr}), 32'h3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("extest_clockdr_lo", 32'(clk_lo_cnt), 32'd4);
    check_eq("extest_updatedr", 32'(upd_cnt), 32'd1);
    check_eq("extest_hi_phase", 32'(hi_viol), 32'd0);

    // Reset asserted mid Shift-DR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("pre_rst_state", 32'(tap_state), 32'h2);
    upd_cnt = 0;
    #4 TRST_b = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(tap_state), 32'hF);
    check_eq("mid_rst_inst", 32'(inst), 32'h3);
    check_eq("mid_rst_tdo_en", 32'(tdo_en), 32'h0);
    @(negedge TCK);
    #1;
    check_eq("mid_rst_updatedr", 32'(updatedr), 32'h0);
    TRST_b = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("post_rst_state", 32'(tap_state), 32'hC);
    check_eq("post_rst_no_upd", 32'(upd_cnt), 32'd0);

    // Undefined opcode decodes as BYPASS; TMS reset restores IDCODE
    shift_ir(4'h7, cap);
    check_eq("undef_inst", 32'(inst), 32'h7);
    dr_scan(4, 32'hD, obs);
    check_eq("undef_bypass_tdo", 32'(obs[4:0]), 32'h1A);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check_eq("tms_rst_state", 32'(tap_state), 32'hF);
    check_eq("tms_rst_inst", 32'(inst), 32'h3);

    // Every state reached, then five TMS=1 cycles back to reset
    for (int s = 0; s < 16; s++) begin
      pb = pbits[s];
      for (int j = 0; j < int'(plen[s]); j++) step(pb[j], 1'b0);
      check_eq($sformatf("walk_state_%0d", s), 32'(tap_state), 32'(pst[s]));
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      check_eq($sformatf("walk_tlr_%0d", s), 32'({tap_state, inst}), 32'hF3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
